cube_renderer_axi_lite_slave: RTL and testbench
===============================================

# cube_renderer_axi_lite_slave

AXI4-Lite responder exposing the cube renderer controller's four 32-bit control registers to the processing system. It accepts single-beat writes and reads from an AXI4-Lite initiator and returns OKAY responses. It drives the register contents, plus a per-register write pulse, to the renderer datapath. It is the slave end of the S00_AXI interface that the BFM example bench exercises at offsets 0x0, 0x4, 0x8 and 0xC.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, address width; bits [3:2] select the register.
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- S_AXI_AWADDR / S_AXI_AWPROT / S_AXI_AWVALID  in  4/3/1  write-address channel; AWPROT is ignored.
- S_AXI_AWREADY  out  1  write-address accept.
- S_AXI_WDATA / S_AXI_WSTRB / S_AXI_WVALID  in  32/4/1  write-data channel.
- S_AXI_WREADY  out  1  write-data accept.
- S_AXI_BRESP / S_AXI_BVALID  out  2/1  write response.
- S_AXI_BREADY  in  1.
- S_AXI_ARADDR / S_AXI_ARPROT / S_AXI_ARVALID  in  4/3/1  read-address channel; ARPROT is ignored.
- S_AXI_ARREADY  out  1.
- S_AXI_RDATA / S_AXI_RRESP / S_AXI_RVALID  out  32/2/1  read-data channel.
- S_AXI_RREADY  in  1.
- reg0_o..reg3_o  out  32 each  current register contents.
- reg_wr_pulse_o  out  4  one-cycle pulse for each register committed.

## Operation
- Write FSM states:
  - W_IDLE: AWREADY=1, WREADY=1.
  - W_HAVE_ADDR: AW accepted. WREADY=1, AWREADY=0.
  - W_HAVE_DATA: W accepted. AWREADY=1, WREADY=0.
  - W_RESP: BVALID=1, both readies 0.
- AW and W may arrive in any order or in the same cycle.
- The address and data are latched at their respective handshakes.
- Commit happens in the cycle the second handshake completes. The FSM then moves to W_RESP.
- W_RESP exits to W_IDLE on BVALID&&BREADY.
- Commit applies per byte: byte k of reg[addr[3:2]] is updated iff WSTRB[k]. WSTRB=0 is a legal no-op write that still produces a response.
- Read FSM states:
  - R_IDLE: ARREADY=1.
  - R_DATA: RVALID=1, ARREADY=0.
- The AR handshake captures reg[ARADDR[3:2]] into the RDATA flop.
- R_DATA exits to R_IDLE on RVALID&&RREADY.
- BRESP and RRESP are always 2'b00 (OKAY). ADDR[1:0] is ignored.
- The write and read FSMs run independently. One outstanding write and one outstanding read are allowed at a time.

## Timing
- Reset: all registers are 0, reg_wr_pulse_o=0, BVALID=RVALID=0, and RDATA=0.
- All readies are held 0 while reset is asserted and for the first cycle after deassertion, gated by an init_done flop. They rise on the second posedge after release.
- Write latency: second handshake at cycle N. The new value is visible on regK_o, reg_wr_pulse_o[K]=1 and BVALID=1 all at N+1.
- Read latency: AR handshake at N gives RVALID/RDATA at N+1.
- Back-to-back throughput: one write per 2 cycles when BREADY is held high. Reads follow the same 2-cycle rule.
- Same-cycle read handshake and write commit to the same register: the read returns the pre-write value.
- BVALID and RVALID hold, with RDATA stable, until accepted. Backpressure of any length is legal.
- Reset asserted mid-transaction: all state clears asynchronously and the in-flight transfer is abandoned. No response is issued after release.

## Structure
- Package cube_renderer_axi_pkg holds:
  - the write-FSM and read-FSM state encodings;
  - RESP_OKAY=2'b00;
  - register index constants REG_CTRL=0 … REG_3=3;
  - NUM_REGS=4.
- Sub-module cube_renderer_reg_file holds the 4×32 storage with byte-strobe write, async-reset clear, a combinational read port and the write-pulse generation.
- The top level contains only the two handshake FSMs and the address/data latches.

## Test plan
- Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011 and 0xBEEF0011 to 0x0/0x4/0x8/0xC, reading each back after its write → every BRESP and RRESP is OKAY and each readback matches.
- W presented 3 cycles before AW, then AW presented 3 cycles before W → both commit correctly; exactly one BVALID per write; reg_wr_pulse_o is a single cycle.
- reg1=0xABCD0001, then write 0x11223344 with WSTRB=4'b0101 → reg1 reads 0xAB220044.
- BREADY held low for 10 cycles → BVALID holds. AWREADY and WREADY stay 0 until B is accepted.
- Same-cycle AR and commit on 0x8 (old 0xDEAD0011, new 0x12345678) → RDATA=0xDEAD0011; a following read returns 0x12345678.
- Reset pulsed while RVALID is pending → RVALID drops immediately, all regs read 0 afterwards, and readies return on the second posedge after release.

Source files
------------

// File: rtl/cube_renderer_axi_pkg.sv
// Shared types and constants for the cube renderer AXI4-Lite control slave.
// The write/read FSM encodings and register indices live here.
package cube_renderer_axi_pkg;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_HAVE_ADDR = 2'd1,
        W_HAVE_DATA = 2'd2,
        W_RESP      = 2'd3
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    typedef logic [1:0] reg_idx_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int         NUM_REGS  = 4;

    localparam reg_idx_t REG_CTRL = 2'd0;
    localparam reg_idx_t REG_1    = 2'd1;
    localparam reg_idx_t REG_2    = 2'd2;
    localparam reg_idx_t REG_3    = 2'd3;

    // Byte-lane merge: lane k takes the new value only when its strobe is set.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) merged[8*k +: 8] = new_val[8*k +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/cube_renderer_reg_file.sv
// Four 32-bit control registers with byte-strobe write, combinational read
// port and a one-cycle write pulse per committed register.
module cube_renderer_reg_file
    import cube_renderer_axi_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  reg_idx_t                  wr_idx,
    input  logic [31:0]               wr_data,
    input  logic [3:0]                wr_strb,
    input  reg_idx_t                  rd_idx,
    output logic [31:0]               rd_data,
    output logic [NUM_REGS-1:0][31:0] regs,
    output logic [NUM_REGS-1:0]       wr_pulse
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this storage is a handful of flops that must read 0 after reset, so it is cleared here; a RAM-style array would not be.
            regs     <= '0;
            wr_pulse <= '0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
            wr_pulse <= '0;
            if (wr_en) begin
                regs[wr_idx]     <= apply_strb(regs[wr_idx], wr_data, wr_strb);
                wr_pulse[wr_idx] <= 1'b1;
            end
        end
    end

    assign rd_data = regs[rd_idx];

endmodule

// File: rtl/cube_renderer_axi_lite_slave.sv
// AXI4-Lite slave for the cube renderer control registers: independent write
// and read handshake FSMs in front of cube_renderer_reg_file.
module cube_renderer_axi_lite_slave
    import cube_renderer_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [31:0]                     reg0_o,
    output logic [31:0]                     reg1_o,
    output logic [31:0]                     reg2_o,
    output logic [31:0]                     reg3_o,
    output logic [3:0]                      reg_wr_pulse_o
);

    w_state_e                  w_state;
    r_state_e                  r_state;
    logic                      init_done;
    reg_idx_t                  awaddr_q;
    logic [31:0]               wdata_q;
    logic [3:0]                wstrb_q;
    logic                      aw_hs, w_hs, ar_hs;
    logic                      wr_en;
    reg_idx_t                  wr_idx;
    logic [31:0]               wr_data;
    logic [3:0]                wr_strb;
    logic [31:0]               rd_data;
    logic [NUM_REGS-1:0][31:0] regs;
    logic                      unused_inputs;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Commit uses whichever half is arriving this cycle, else the latched half.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        wr_en   = 1'b0;
        wr_idx  = awaddr_q;
        wr_data = wdata_q;
        wr_strb = wstrb_q;
        if (aw_hs) wr_idx = S_AXI_AWADDR[3:2];
        if (w_hs) begin
            wr_data = S_AXI_WDATA;
            wr_strb = S_AXI_WSTRB;
        end
        case (w_state)
            W_IDLE:      wr_en = aw_hs && w_hs;
            W_HAVE_ADDR: wr_en = w_hs;
            W_HAVE_DATA: wr_en = aw_hs;
            default:     wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) init_done <= 1'b0;
        else                init_done <= 1'b1;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            if (aw_hs) awaddr_q <= S_AXI_AWADDR[3:2];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            case (w_state)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        w_state       <= W_RESP;
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b0;
                        S_AXI_BVALID  <= 1'b1;
                    end else if (aw_hs) begin
                        w_state       <= W_HAVE_ADDR;
                        S_AXI_AWREADY <= 1'b0;
                    end else if (w_hs) begin
                        w_state       <= W_HAVE_DATA;
                        S_AXI_WREADY  <= 1'b0;
                    end else begin
                        S_AXI_AWREADY <= init_done;
                        S_AXI_WREADY  <= init_done;
                    end
                end
                W_HAVE_ADDR: if (w_hs) begin
                    w_state      <= W_RESP;
                    S_AXI_WREADY <= 1'b0;
                    S_AXI_BVALID <= 1'b1;
                end
                W_HAVE_DATA: if (aw_hs) begin
                    w_state       <= W_RESP;
                    S_AXI_AWREADY <= 1'b0;
                    S_AXI_BVALID  <= 1'b1;
                end
                default: if (S_AXI_BREADY) begin
                    w_state       <= W_IDLE;
                    S_AXI_BVALID  <= 1'b0;
                    S_AXI_AWREADY <= 1'b1;
                    S_AXI_WREADY  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state       <= R_DATA;
                        S_AXI_RDATA   <= rd_data;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_ARREADY <= 1'b0;
                    end else begin
                        S_AXI_ARREADY <= init_done;
                    end
                end
                default: if (S_AXI_RREADY) begin
                    r_state       <= R_IDLE;
                    S_AXI_RVALID  <= 1'b0;
                    S_AXI_ARREADY <= 1'b1;
                end
            endcase
        end
    end

    assign S_AXI_BRESP = RESP_OKAY;
    assign S_AXI_RRESP = RESP_OKAY;

    cube_renderer_reg_file u_reg_file (
        .clk      (S_AXI_ACLK),
        .rst_n    (S_AXI_ARESETN),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .wr_strb  (wr_strb),
        .rd_idx   (S_AXI_ARADDR[3:2]),
        .rd_data  (rd_data),
        .regs     (regs),
        .wr_pulse (reg_wr_pulse_o)
    );

    assign reg0_o = regs[REG_CTRL];
    assign reg1_o = regs[REG_1];
    assign reg2_o = regs[REG_2];
    assign reg3_o = regs[REG_3];

endmodule

// File: tb/tb_cube_renderer_axi_lite_slave.sv
// Self-checking bench for cube_renderer_axi_lite_slave: directed scenarios plus
// randomized single-beat traffic against a byte-lane register model.
module tb_cube_renderer_axi_lite_slave;

    logic        tb_ACLK = 1'b0;
    logic        tb_ARESETN;
    logic [3:0]  S_AXI_AWADDR, S_AXI_ARADDR;
    logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
    logic        S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID, S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY;
    logic        S_AXI_ARVALID, S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic [31:0] reg0_o, reg1_o, reg2_o, reg3_o;
    logic [3:0]  reg_wr_pulse_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model [4];

    always #5 tb_ACLK = ~tb_ACLK;

    cube_renderer_axi_lite_slave dut (
        .S_AXI_ACLK     (tb_ACLK),
        .S_AXI_ARESETN  (tb_ARESETN),
        .S_AXI_AWADDR   (S_AXI_AWADDR),
        .S_AXI_AWPROT   (S_AXI_AWPROT),
        .S_AXI_AWVALID  (S_AXI_AWVALID),
        .S_AXI_AWREADY  (S_AXI_AWREADY),
        .S_AXI_WDATA    (S_AXI_WDATA),
        .S_AXI_WSTRB    (S_AXI_WSTRB),
        .S_AXI_WVALID   (S_AXI_WVALID),
        .S_AXI_WREADY   (S_AXI_WREADY),
        .S_AXI_BRESP    (S_AXI_BRESP),
        .S_AXI_BVALID   (S_AXI_BVALID),
        .S_AXI_BREADY   (S_AXI_BREADY),
        .S_AXI_ARADDR   (S_AXI_ARADDR),
        .S_AXI_ARPROT   (S_AXI_ARPROT),
        .S_AXI_ARVALID  (S_AXI_ARVALID),
        .S_AXI_ARREADY  (S_AXI_ARREADY),
        .S_AXI_RDATA    (S_AXI_RDATA),
        .S_AXI_RRESP    (S_AXI_RRESP),
        .S_AXI_RVALID   (S_AXI_RVALID),
        .S_AXI_RREADY   (S_AXI_RREADY),
        .reg0_o         (reg0_o),
        .reg1_o         (reg1_o),
        .reg2_o         (reg2_o),
        .reg3_o         (reg3_o),
        .reg_wr_pulse_o (reg_wr_pulse_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_reg(input int idx);
        case (idx)
            0:       return reg0_o;
            1:       return reg1_o;
            2:       return reg2_o;
            default: return reg3_o;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++)
            if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
        return r;
    endfunction

    // Presents AW and W after independent delays, then holds BREADY low b_dly cycles.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit          aw_done = 0, w_done = 0, aw_fire, w_fire;
        int          idx = int'(addr[3:2]);
        logic [31:0] exp;
        exp = merge(model[idx], data, strb);
        S_AXI_AWADDR = addr;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        for (int cyc = 0; cyc < 64 && !(aw_done && w_done); cyc++) begin
            S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
            S_AXI_WVALID  = !w_done && (cyc >= w_dly);
            aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
            w_fire  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge tb_ACLK);
            @(negedge tb_ACLK);
            aw_done = aw_done | aw_fire;
            w_done  = w_done | w_fire;
            if (!(aw_done && w_done)) check("b_early", {31'd0, S_AXI_BVALID}, 32'd0);
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", {30'd0, aw_done, w_done}, 32'd3);
            return;
        end
        model[idx] = exp;
        check("bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
        check("bresp", {30'd0, S_AXI_BRESP}, 32'd0);
        check($sformatf("reg%0d_after_wr", idx), dut_reg(idx), exp);
        if (strb != 4'd0) check("wr_pulse", {28'd0, reg_wr_pulse_o}, 32'd1 << idx);
        for (int i = 0; i < b_dly; i++) begin
            check("b_hold", {29'd0, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 32'b100);
            @(posedge tb_ACLK);
            @(negedge tb_ACLK);
        end
        S_AXI_BREADY = 1'b1;
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        S_AXI_BREADY = 1'b0;
        check("b_done", {25'd0, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, reg_wr_pulse_o},
              {25'd0, 3'b011, 4'b0000});
    endtask

    task automatic axi_read(input logic [3:0] addr, input int r_dly);
        bit          fired = 0, fire;
        logic [31:0] exp;
        exp = model[addr[3:2]];
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        for (int cyc = 0; cyc < 64 && !fired; cyc++) begin
            fire = S_AXI_ARREADY;
            @(posedge tb_ACLK);
            @(negedge tb_ACLK);
            fired = fire;
        end
        S_AXI_ARVALID = 1'b0;
        if (!fired) begin
            check("rd_handshake_timeout", {31'd0, fired}, 32'd1);
            return;
        end
        check("rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
        check("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
        check($sformatf("rdata@%0h", addr), S_AXI_RDATA, exp);
        for (int i = 0; i < r_dly; i++) begin
            @(posedge tb_ACLK);
            @(negedge tb_ACLK);
            check("r_hold_flags", {30'd0, S_AXI_RVALID, S_AXI_ARREADY}, 32'b10);
            check("r_hold_data", S_AXI_RDATA, exp);
        end
        S_AXI_RREADY = 1'b1;
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        S_AXI_RREADY = 1'b0;
        check("r_done", {30'd0, S_AXI_RVALID, S_AXI_ARREADY}, 32'b01);
    endtask

    initial begin
        tb_ARESETN    = 1'b0;
        S_AXI_AWADDR  = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0; S_AXI_WSTRB  = '0; S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 32'd0;

        repeat (2) @(negedge tb_ACLK);
        for (int i = 0; i < 4; i++) check($sformatf("rst_reg%0d", i), dut_reg(i), 32'd0);
        check("rst_flags", {23'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                            S_AXI_RVALID, reg_wr_pulse_o}, 32'd0);
        check("rst_rdata", S_AXI_RDATA, 32'd0);
        tb_ARESETN = 1'b1;
        @(posedge tb_ACLK); @(negedge tb_ACLK);
        check("ready_after_1st_edge", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'b000);
        @(posedge tb_ACLK); @(negedge tb_ACLK);
        check("ready_after_2nd_edge", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'b111);

        // Basic writes with readback
        axi_write(4'h0, 32'h0101FFFF, 4'hF, 0, 0, 0); axi_read(4'h0, 0);
        axi_write(4'h4, 32'hABCD0001, 4'hF, 0, 0, 0); axi_read(4'h4, 0);
        axi_write(4'h8, 32'hDEAD0011, 4'hF, 0, 0, 0); axi_read(4'h8, 0);
        axi_write(4'hC, 32'hBEEF0011, 4'hF, 0, 0, 0); axi_read(4'hC, 0);

        // Partial strobe on reg1
        axi_write(4'h4, 32'h11223344, 4'b0101, 0, 0, 0);
        check("strb_reg1", reg1_o, 32'hAB220044);
        axi_read(4'h4, 2);

        // W leads AW by 3 cycles, then AW leads W by 3 cycles
        axi_write(4'hC, 32'hCAFE0003, 4'hF, 3, 0, 0);
        axi_write(4'h0, 32'h5A5A1234, 4'hF, 0, 3, 0);
        axi_read(4'hC, 0);

        // Write-response backpressure
        axi_write(4'hC, 32'h0BADF00D, 4'hF, 0, 0, 10);

        // Same-cycle read handshake and write commit on reg2
        check("sc_old_reg2", reg2_o, 32'hDEAD0011);
        S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 4'h8;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        check("sc_readies", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'b111);
        @(posedge tb_ACLK); @(negedge tb_ACLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        check("sc_valids", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'b11);
        check("sc_rdata_old", S_AXI_RDATA, 32'hDEAD0011);
        check("sc_reg2_new", reg2_o, 32'h12345678);
        model[2] = 32'h12345678;
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        @(posedge tb_ACLK); @(negedge tb_ACLK);
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        axi_read(4'h8, 0);

        // Randomized traffic, ADDR[1:0] randomized too
        for (int n = 0; n < 60; n++) begin
            logic [3:0] a;
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0)
                axi_read(a, int'($urandom_range(0, 3)));
            else
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Reset while a read response is pending
        S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
        check("pre_rst_arready", {31'd0, S_AXI_ARREADY}, 32'd1);
        @(posedge tb_ACLK); @(negedge tb_ACLK);
        S_AXI_ARVALID = 1'b0;
        check("pre_rst_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
        #2 tb_ARESETN = 1'b0;
        #1;
        check("mid_rst_flags", {27'd0, S_AXI_RVALID, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_AWREADY,
                                S_AXI_WREADY}, 32'd0);
        check("mid_rst_rdata", S_AXI_RDATA, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mid_rst_reg%0d", i), dut_reg(i), 32'd0);
            model[i] = 32'd0;
        end
        @(negedge tb_ACLK);
        tb_ARESETN = 1'b1;
        @(posedge tb_ACLK); @(negedge tb_ACLK);
        check("rel_ready_1st_edge", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'b000);
        @(posedge tb_ACLK); @(negedge tb_ACLK);
        check("rel_ready_2nd_edge", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'b111);
        check("rel_no_resp", {30'd0, S_AXI_RVALID, S_AXI_BVALID}, 32'd0);
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
